// File: rtl/maze_pkg.sv
// maze_pkg: shared types, start positions and helpers for the sprite scheduler
package maze_pkg;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MOVE, S_DONE} state_t;
  localparam int N_SPRITES_DEF = 5;
  localparam logic [9:0] START_X [N_SPRITES_DEF] = '{10'd47, 10'd47, 10'd45, 10'd49, 10'd51};
  localparam logic [8:0] START_Y [N_SPRITES_DEF] = '{9'd64, 9'd40, 9'd40, 9'd40, 9'd40};
  // sprites beyond the table reuse the last ghost's start cell
  function automatic logic [9:0] start_x(input int i);
    return i < N_SPRITES_DEF ? START_X[3'(i)] : START_X[N_SPRITES_DEF-1];
  endfunction
  function automatic logic [8:0] start_y(input int i);
    return i < N_SPRITES_DEF ? START_Y[3'(i)] : START_Y[N_SPRITES_DEF-1];
  endfunction
  // en is {up, down, right, left}
  function automatic logic allows(input dir_t d, input logic [3:0] en);
    return d == UP ? en[3] : d == DOWN ? en[2] : d == LEFT ? en[0] : en[1];
  endfunction
endpackage

// File: rtl/sprite_step.sv
// sprite_step: one sprite's move decision (buffered turn first, else keep going) with saturating step
module sprite_step
  import maze_pkg::*;
(
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  dir_t       dir_i,
  input  logic       pend_v_i,
  input  dir_t       pend_d_i,
  input  logic [3:0] en_i,
  output logic [9:0] x_o,
  output logic [8:0] y_o,
  output dir_t       dir_o,
  output logic       moving_o,
  output logic       clear_pend_o
);
  // turn wins when the maze allows it; stepping off either edge of the coordinate range holds
  always_comb begin
    clear_pend_o = pend_v_i && allows(pend_d_i, en_i);
    dir_o = clear_pend_o ? pend_d_i : dir_i;
    moving_o = clear_pend_o || allows(dir_i, en_i);
    x_o = !moving_o ? x_i : dir_o == LEFT ? (x_i == '0 ? x_i : x_i - 10'd1) : dir_o == RIGHT ? (&x_i ? x_i : x_i + 10'd1) : x_i;
    y_o = !moving_o ? y_i : dir_o == UP ? (y_i == '0 ? y_i : y_i - 9'd1) : dir_o == DOWN ? (&y_i ? y_i : y_i + 9'd1) : y_i;
  end
endmodule

// File: rtl/sprite_move_scheduler.sv
// sprite_move_scheduler: per-frame sweep that moves every sprite through one shared maze lookup
module sprite_move_scheduler
  import maze_pkg::*;
#(
  parameter int N_SPRITES = N_SPRITES_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic [N_SPRITES-1:0]   req_valid,
  input  logic [2*N_SPRITES-1:0] req_dir,
  output logic [9:0]             maze_x,
  output logic [8:0]             maze_y,
  input  logic                   uE,
  input  logic                   dE,
  input  logic                   rE,
  input  logic                   lE,
  output logic [10*N_SPRITES-1:0] sprite_x,
  output logic [9*N_SPRITES-1:0]  sprite_y,
  output logic [2*N_SPRITES-1:0]  sprite_dir,
  output logic [N_SPRITES-1:0]   moving,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);
  localparam int IW = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0] x_q [N_SPRITES];
  logic [8:0] y_q [N_SPRITES];
  dir_t dir_q [N_SPRITES];
  dir_t pend_d_q [N_SPRITES];
  logic [N_SPRITES-1:0] pend_v_q, moving_q;
  logic [3:0] en_q;
  logic overrun_q, last;
  logic [9:0] step_x;
  logic [8:0] step_y;
  dir_t step_dir;
  logic step_mov, step_clr;
  assign last = idx_q == IW'(N_SPRITES - 1);
  // one ADDR/MOVE pair per sprite, then a single DONE cycle
  always_comb begin
    state_d = state_q == S_IDLE ? (frame_tick ? S_ADDR : S_IDLE) : state_q == S_ADDR ? S_MOVE : state_q == S_MOVE ? (last ? S_DONE : S_ADDR) : S_IDLE;
    idx_d = state_q == S_IDLE ? '0 : (state_q == S_MOVE && !last) ? idx_q + 1'b1 : idx_q;
  end
  assign maze_x = state_q == S_ADDR ? x_q[idx_q] : '0;
  assign maze_y = state_q == S_ADDR ? y_q[idx_q] : '0;
  assign busy = state_q == S_ADDR || state_q == S_MOVE;
  assign done = state_q == S_DONE;
  assign overrun = overrun_q;
  sprite_step u_step (
    .x_i(x_q[idx_q]),
    .y_i(y_q[idx_q]),
    .dir_i(dir_q[idx_q]),
    .pend_v_i(pend_v_q[idx_q]),
    .pend_d_i(pend_d_q[idx_q]),
    .en_i(en_q),
    .x_o(step_x),
    .y_o(step_y),
    .dir_o(step_dir),
    .moving_o(step_mov),
    .clear_pend_o(step_clr)
  );
  // sweep control, maze enables sampled at the end of ADDR, sticky overrun on a tick while not idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      en_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (state_q == S_ADDR) en_q <= {uE, dE, rE, lE};
      if (frame_tick && state_q != S_IDLE) overrun_q <= 1'b1;
    end
  end
  // sprite state commits at the end of its MOVE; a fresh request overrides the clear of the one just used
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int j = 0; j < N_SPRITES; j++) begin
        x_q[j] <= start_x(j);
        y_q[j] <= start_y(j);
        dir_q[j] <= LEFT;
        pend_d_q[j] <= LEFT;
      end
      pend_v_q <= '0;
      moving_q <= '0;
    end else begin
      for (int j = 0; j < N_SPRITES; j++) begin
        if (state_q == S_MOVE && idx_q == IW'(j)) begin
          x_q[j] <= step_x;
          y_q[j] <= step_y;
          dir_q[j] <= step_dir;
          moving_q[j] <= step_mov;
          if (step_clr) pend_v_q[j] <= 1'b0;
        end
        if (req_valid[j]) begin
          pend_v_q[j] <= 1'b1;
          pend_d_q[j] <= dir_t'(req_dir[2*j +: 2]);
        end
      end
    end
  end
  for (genvar g = 0; g < N_SPRITES; g++) begin : g_out
    assign sprite_x[10*g +: 10] = x_q[g];
    assign sprite_y[9*g +: 9] = y_q[g];
    assign sprite_dir[2*g +: 2] = dir_q[g];
  end
  assign moving = moving_q;
endmodule

// File: tb/tb_sprite_move_scheduler.sv
// tb_sprite_move_scheduler: random and directed sweeps against an event-level sprite model
module tb_sprite_move_scheduler;
  localparam int N = 5;
  logic Clk = 0, Reset = 1, frame_tick = 0;
  logic [N-1:0] req_valid = '0;
  logic [2*N-1:0] req_dir = '0;
  logic [9:0] maze_x;
  logic [8:0] maze_y;
  logic uE, dE, rE, lE;
  logic [10*N-1:0] sprite_x;
  logic [9*N-1:0] sprite_y;
  logic [2*N-1:0] sprite_dir;
  logic [N-1:0] moving;
  logic busy, done, overrun;
  int total = 0, bad = 0;
  int maze_mode = 0;
  logic [3:0] rnd_tab [64];
  int mx [N], my [N], md [N], mmov [N], mpv [N], mpd [N];
  int m_ovr = 0;
  const int SX [N] = '{47, 47, 45, 49, 51};
  const int SY [N] = '{64, 40, 40, 40, 40};

  sprite_move_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .req_valid(req_valid), .req_dir(req_dir),
    .maze_x(maze_x), .maze_y(maze_y), .uE(uE), .dE(dE), .rE(rE), .lE(lE),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_dir(sprite_dir), .moving(moving),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // maze: 0 = corridor (left open above x=7, up only in column 22), 1 = random table, 2 = open field
  function automatic logic [3:0] maze_en(input int x, input int y);
    logic u, l;
    u = (x == 22);
    l = (x > 7);
    if (maze_mode == 0) return {u, 1'b0, 1'b0, l};
    if (maze_mode == 1) return rnd_tab[(x + 5 * y) % 64];
    return 4'hF;
  endfunction

  assign {uE, dE, rE, lE} = maze_en(int'(maze_x), int'(maze_y));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit open_dir(input int d, input logic [3:0] en);
    bit u, dn, r, l;
    {u, dn, r, l} = en;
    case (d)
      0: return u;
      1: return dn;
      2: return l;
      default: return r;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = SX[i]; my[i] = SY[i]; md[i] = 2; mmov[i] = 0; mpv[i] = 0; mpd[i] = 2;
    end
    m_ovr = 0;
  endtask

  task automatic model_move(input int i);
    logic [3:0] en;
    int nx, ny;
    en = maze_en(mx[i], my[i]);
    mmov[i] = 0;
    if (mpv[i] != 0 && open_dir(mpd[i], en)) begin
      md[i] = mpd[i]; mpv[i] = 0; mmov[i] = 1;
    end else if (open_dir(md[i], en)) mmov[i] = 1;
    if (mmov[i] != 0) begin
      nx = mx[i] + (md[i] == 3 ? 1 : 0) - (md[i] == 2 ? 1 : 0);
      ny = my[i] + (md[i] == 1 ? 1 : 0) - (md[i] == 0 ? 1 : 0);
      if (nx >= 0 && nx <= 1023) mx[i] = nx;
      if (ny >= 0 && ny <= 511) my[i] = ny;
    end
  endtask

  task automatic model_req();
    for (int i = 0; i < N; i++)
      if (req_valid[i]) begin
        mpv[i] = 1;
        mpd[i] = int'(req_dir[2*i +: 2]);
      end
  endtask

  task automatic drive_req(input int pct, input int fi, input int fd);
    req_valid = '0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(99) < pct) begin
        req_valid[i] = 1'b1;
        req_dir[2*i +: 2] = 2'($urandom_range(3));
      end
    if (fi >= 0) begin
      req_valid[fi] = 1'b1;
      req_dir[2*fi +: 2] = 2'(fd);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("x%0d", i), int'(sprite_x[10*i +: 10]), mx[i]);
      check($sformatf("y%0d", i), int'(sprite_y[9*i +: 9]), my[i]);
      check($sformatf("dir%0d", i), int'(sprite_dir[2*i +: 2]), md[i]);
      check($sformatf("mov%0d", i), int'(moving[i]), mmov[i]);
    end
    check("overrun", int'(overrun), m_ovr);
  endtask

  // one frame: tick, optional extra tick at cycle xt, random requests, forced request fi/fd at cycle fj
  task automatic sweep(input int pct, input int xt, input int fi, input int fd, input int fj);
    int lat, nb;
    lat = -1; nb = 0;
    @(negedge Clk);
    frame_tick = 1;
    drive_req(pct, -1, 0);
    @(posedge Clk);
    model_req();
    for (int j = 1; j <= 2 * N + 1; j++) begin
      @(negedge Clk);
      frame_tick = (j == xt);
      drive_req(pct, j == fj ? fi : -1, fd);
      if (busy) nb++;
      if (done && lat < 0) lat = j;
      @(posedge Clk);
      if (j >= 2 && j % 2 == 0 && j <= 2 * N) model_move((j - 2) / 2);
      model_req();
      if (j == xt) m_ovr = 1;
    end
    @(negedge Clk);
    frame_tick = 0;
    req_valid = '0;
    check("done_after", int'(done), 0);
    check("done_lat", lat, 2 * N + 1);
    check("busy_cycles", nb, 2 * N);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    model_reset();
  endtask

  task automatic single_req(input int i, input int d);
    @(negedge Clk);
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_dir[2*i +: 2] = 2'(d);
    @(posedge Clk);
    model_req();
    @(negedge Clk);
    req_valid = '0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++) rnd_tab[i] = 4'($urandom_range(15));
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_maze_x", int'(maze_x), 0);
    check("rst_maze_y", int'(maze_y), 0);
    check_all();
    // corridor: first step, then wait in front of column 22 with UP buffered
    maze_mode = 0;
    sweep(0, -1, -1, 0, -1);
    check("t1_x0", int'(sprite_x[9:0]), 46);
    check("t1_y0", int'(sprite_y[8:0]), 64);
    check("t1_mov0", int'(moving[0]), 1);
    repeat (23) sweep(0, -1, -1, 0, -1);
    check("t2_x0_23", int'(sprite_x[9:0]), 23);
    single_req(0, 0);
    sweep(0, -1, -1, 0, -1);
    check("t2_x0_22", int'(sprite_x[9:0]), 22);
    check("t2_dir_left", int'(sprite_dir[1:0]), 2);
    sweep(0, -1, -1, 0, -1);
    check("t2_dir_up", int'(sprite_dir[1:0]), 0);
    check("t2_x0", int'(sprite_x[9:0]), 22);
    check("t2_y0", int'(sprite_y[8:0]), 63);
    // wall at x=7
    do_reset();
    repeat (42) sweep(0, -1, -1, 0, -1);
    check("t3_x0", int'(sprite_x[9:0]), 7);
    check("t3_mov0", int'(moving[0]), 0);
    check("t3_dir0", int'(sprite_dir[1:0]), 2);
    // overrun
    do_reset();
    sweep(0, 4, -1, 0, -1);
    check("t4_ovr", int'(overrun), 1);
    sweep(0, -1, -1, 0, -1);
    check("t4_ovr_sticky", int'(overrun), 1);
    do_reset();
    check("t4_ovr_clr", int'(overrun), 0);
    // reset in sprite 2 MOVE
    @(negedge Clk);
    frame_tick = 1;
    @(negedge Clk);
    frame_tick = 0;
    repeat (5) @(negedge Clk);
    Reset = 1;
    #1;
    model_reset();
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check_all();
    @(negedge Clk);
    Reset = 0;
    cnt = 0;
    repeat (15) begin
      @(negedge Clk);
      if (done) cnt++;
    end
    check("t5_no_done", cnt, 0);
    check_all();
    // request arriving in sprite 0's MOVE: old UP used, RIGHT stays pending
    maze_mode = 2;
    do_reset();
    single_req(0, 0);
    sweep(0, -1, 0, 3, 2);
    check("t6_dir_up", int'(sprite_dir[1:0]), 0);
    check("t6_y0", int'(sprite_y[8:0]), 63);
    sweep(0, -1, -1, 0, -1);
    check("t6_dir_right", int'(sprite_dir[1:0]), 3);
    check("t6_x0", int'(sprite_x[9:0]), 48);
    // random maze with random requests
    maze_mode = 1;
    do_reset();
    repeat (40) sweep(30, -1, -1, 0, -1);
    // saturation at zero in both axes
    maze_mode = 2;
    do_reset();
    repeat (52) sweep(0, -1, -1, 0, -1);
    check("t7_x0_sat", int'(sprite_x[9:0]), 0);
    check("t7_mov0_sat", int'(moving[0]), 1);
    for (int i = 0; i < N; i++) single_req(i, 0);
    repeat (66) sweep(0, -1, -1, 0, -1);
    check("t7_y0_sat", int'(sprite_y[8:0]), 0);
    check("t7_x4_sat", int'(sprite_x[49:40]), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
